// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry sample buffer feeding a 64-slot frame.
// The mono sample is duplicated to both channels, MSB first, one slot after each word-select change.
module i2s_tx #(
  parameter int unsigned width_p   = 24,
  parameter int unsigned clk_div_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] sample_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               sclk_o,
  output logic               lrclk_o,
  output logic               sdata_o,
  output logic               underrun_o
);

  localparam int unsigned DivW = 8;

  logic [DivW-1:0]    div_q, div_d;
  logic               sclk_q, sclk_d;
  logic [5:0]         slot_q, slot_d;
  logic               lrclk_q, lrclk_d;
  logic               sdata_q, sdata_d;
  logic               underrun_q, underrun_d;
  logic               buf_full_q, buf_full_d;
  logic [width_p-1:0] buf_q, buf_d;
  logic [width_p-1:0] active_q, active_d;

  logic       div_wrap;
  logic       slot_edge;
  logic       boundary;
  logic       accept;
  logic [5:0] slot_next;
  logic [4:0] bit_idx;
  logic       data_slot;

  assign ready_o    = ~buf_full_q & ~reset_i;
  assign sclk_o     = sclk_q;
  assign lrclk_o    = lrclk_q;
  assign sdata_o    = sdata_q;
  assign underrun_o = underrun_q;

  always_comb begin
    div_wrap  = (div_q == DivW'(clk_div_p - 1));
    slot_edge = div_wrap & sclk_q;
    boundary  = slot_edge & (slot_q == 6'd63);
    accept    = valid_i & ready_o;
    slot_next = slot_q + 6'd1;
    // Both channels share the in-channel slot position, so the low 5 bits pick the sample bit.
    bit_idx   = 5'(width_p) - slot_next[4:0];
    data_slot = (slot_next[4:0] != 5'd0) && (slot_next[4:0] <= 5'(width_p));

    div_d      = div_wrap ? '0 : div_q + DivW'(1);
    sclk_d     = div_wrap ? ~sclk_q : sclk_q;
    slot_d     = slot_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    active_d   = active_q;

    if (slot_edge) begin
      slot_d  = slot_next;
      lrclk_d = slot_next[5];
      sdata_d = data_slot ? active_q[bit_idx] : 1'b0;
    end

    if (boundary) begin
      if (buf_full_q) begin
        active_d   = buf_q;
        buf_full_d = 1'b0;
      end else begin
        active_d   = '0;
        underrun_d = 1'b1;
      end
    end

    // A write can only be accepted into an empty buffer, so it never races the boundary handoff.
    if (accept) begin
      buf_d      = sample_i;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div_q      <= '0;
      sclk_q     <= 1'b0;
      slot_q     <= '0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      active_q   <= '0;
    end else begin
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      slot_q     <= slot_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      active_q   <= active_d;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed testbench for i2s_tx with clk_div_p = 4 (slot = 8 cycles, frame = 512 cycles).
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] sample;
  logic        valid;
  logic        ready;
  logic        sclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  i2s_tx #(
    .width_p  (24),
    .clk_div_p(4)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .sample_i  (sample),
    .valid_i   (valid),
    .ready_o   (ready),
    .sclk_o    (sclk),
    .lrclk_o   (lrclk),
    .sdata_o   (sdata),
    .underrun_o(underrun)
  );

  task automatic chk1(input logic got, input logic exp, input string tag);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_int(input int got, input int exp, input string tag);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // cyc counts rising edges since the last reset release; sampling is 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_cyc(input int c);
    if (c > cyc) tick(c - cyc);
  endtask

  task automatic push(input logic [23:0] d, input string tag);
    valid  = 1'b1;
    sample = d;
    for (int i = 0; i < 1024 && !ready; i++) tick(1);
    chk1(ready, 1'b1, {tag, "_ready"});
    tick(1);
    valid  = 1'b0;
    sample = 24'h3C3C3C;
  endtask

  task automatic check_frame(input int f, input logic [23:0] smp, input string tag);
    logic e;
    for (int s = 0; s < 64; s++) begin
      wait_cyc(512 * f + 8 * s + 4);
      if (s >= 1 && s <= 24)       e = smp[24 - s];
      else if (s >= 33 && s <= 56) e = smp[56 - s];
      else                         e = 1'b0;
      chk1(lrclk, (s >= 32), $sformatf("%s_lr_s%0d", tag, s));
      chk1(sdata, e, $sformatf("%s_sd_s%0d", tag, s));
    end
  endtask

  task automatic check_boundary(input int k, input logic exp_ur, input logic exp_rdy,
                                input string tag);
    wait_cyc(512 * k - 1);
    chk1(underrun, 1'b0, {tag, "_ur_before"});
    wait_cyc(512 * k);
    chk1(underrun, exp_ur, {tag, "_ur_at"});
    chk1(ready, exp_rdy, {tag, "_ready_at"});
    wait_cyc(512 * k + 1);
    chk1(underrun, 1'b0, {tag, "_ur_after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    valid  = 1'b0;
    sample = '0;

    tick(10);
    chk1(sclk, 1'b0, "rst_sclk");
    chk1(lrclk, 1'b0, "rst_lrclk");
    chk1(sdata, 1'b0, "rst_sdata");
    chk1(underrun, 1'b0, "rst_underrun");
    chk1(ready, 1'b0, "rst_ready");

    reset = 1'b0;
    cyc   = 0;
    #1;
    chk1(ready, 1'b1, "rel_ready");
    wait_cyc(3);
    chk1(sclk, 1'b0, "sclk_c3");
    wait_cyc(4);
    chk1(sclk, 1'b1, "sclk_rise_c4");
    wait_cyc(7);
    chk1(sclk, 1'b1, "sclk_c7");
    wait_cyc(8);
    chk1(sclk, 1'b0, "sclk_fall_c8");
    chk1(lrclk, 1'b0, "lrclk_c8");

    // Push A, then hold B against back-pressure until the frame boundary frees the buffer.
    wait_cyc(10);
    push(24'hA5F00F, "push_a");
    chk1(ready, 1'b0, "ready_after_a");
    valid  = 1'b1;
    sample = 24'h800000;
    for (int i = 0; i < 1024 && !ready; i++) tick(1);
    chk_int(cyc, 512, "bp_ready_cycle");
    chk1(underrun, 1'b0, "bp_no_underrun");
    tick(1);
    valid  = 1'b0;
    sample = 24'h3C3C3C;
    chk1(ready, 1'b0, "ready_after_b");

    check_frame(1, 24'hA5F00F, "f1_a");
    check_boundary(2, 1'b0, 1'b1, "b2");
    push(24'h000001, "push_c");
    check_frame(2, 24'h800000, "f2_msb");
    check_boundary(3, 1'b0, 1'b1, "b3");
    check_frame(3, 24'h000001, "f3_lsb");
    check_boundary(4, 1'b1, 1'b1, "b4_underrun");
    check_frame(4, 24'h000000, "f4_zero");

    // Write lands on the same edge as an empty-buffer boundary.
    wait_cyc(2559);
    chk1(underrun, 1'b0, "sim_ur_before");
    chk1(ready, 1'b1, "sim_ready_before");
    valid  = 1'b1;
    sample = 24'h123456;
    tick(1);
    valid  = 1'b0;
    sample = 24'h3C3C3C;
    chk1(underrun, 1'b1, "sim_ur_at");
    chk1(ready, 1'b0, "sim_ready_at");
    tick(1);
    chk1(underrun, 1'b0, "sim_ur_after");
    check_frame(5, 24'h000000, "f5_zero");
    check_boundary(6, 1'b0, 1'b1, "b6");
    push(24'hFFFFFF, "push_e");
    check_frame(6, 24'h123456, "f6_d");
    check_boundary(7, 1'b0, 1'b1, "b7");
    push(24'h5A5A5A, "push_f");
    chk1(ready, 1'b0, "ready_after_f");

    // Asynchronous reset at slot 10 of frame 7 with F buffered.
    wait_cyc(3584 + 84);
    chk1(sdata, 1'b1, "pre_rst_sdata");
    chk1(sclk, 1'b1, "pre_rst_sclk");
    chk1(lrclk, 1'b0, "pre_rst_lrclk");
    #2;
    reset = 1'b1;
    #1;
    chk1(sclk, 1'b0, "mid_rst_sclk");
    chk1(lrclk, 1'b0, "mid_rst_lrclk");
    chk1(sdata, 1'b0, "mid_rst_sdata");
    chk1(underrun, 1'b0, "mid_rst_underrun");
    chk1(ready, 1'b0, "mid_rst_ready");
    tick(3);
    reset = 1'b0;
    cyc   = 0;
    #1;
    chk1(ready, 1'b1, "rel2_ready");
    check_frame(0, 24'h000000, "r2_f0");
    check_boundary(1, 1'b1, 1'b1, "r2_b1");
    check_frame(1, 24'h000000, "r2_f1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter: width_p, 24, sample width in bits; SHALL be fixed at 24 for this block.
REQ-002 Parameter: clk_div_p, 4, number of clk_i cycles per SCLK half-period; legal range 2..255.
REQ-003 Port: clk_i  in  1  single system clock; all state SHALL change on its rising edge.
REQ-004 Port: reset_i  in  1  reset; asynchronous, active-high.
REQ-005 Port: sample_i  in  24  signed PCM sample from the sound-playback block (its sound_o).
REQ-006 Port: valid_i  in  1  sample_i is valid this cycle.
REQ-007 Port: ready_o  out  1  the block can accept a sample this cycle; transfer occurs when valid_i & ready_o.
REQ-008 Port: sclk_o  out  1  I2S bit clock.
REQ-009 Port: lrclk_o  out  1  I2S word select; 0 = left, 1 = right.
REQ-010 Port: sdata_o  out  1  I2S serial data, MSB first.
REQ-011 Port: underrun_o  out  1  one-cycle pulse when a frame starts with no buffered sample.

Function
REQ-012 Divider counter SHALL count 0..clk_div_p-1; on the cycle it equals clk_div_p-1, it SHALL wrap to 0 and sclk_o SHALL toggle on the next edge.
REQ-013 A falling toggle of sclk_o (1->0) is a slot edge: the 6-bit slot counter SHALL advance by 1, wrapping 63->0. lrclk_o and sdata_o SHALL update only on slot edges, registered in the same edge as sclk_o.
REQ-014 Frame = 64 slots. lrclk_o SHALL be 0 for slots 0..31 and 1 for slots 32..63.
REQ-015 sdata_o SHALL carry bit (24-s) of the active frame sample in slots s = 1..24. It SHALL carry bit (56-s) of the same sample in slots s = 33..56 (mono duplicated to both channels; one-slot I2S delay after each lrclk_o change). sdata_o SHALL be 0 in slots 0, 25..32 and 57..63.
REQ-016 One-entry holding buffer; ready_o SHALL equal ~buffer_full while reset_i is low, and SHALL be 0 while reset_i is high.
REQ-017 On valid_i & ready_o the buffer SHALL capture sample_i, and ready_o SHALL be 0 from the next cycle.
REQ-018 Frame boundary = the slot edge 63->0. If the buffer is full at that edge, its contents SHALL become the active frame sample and the buffer SHALL empty, so ready_o = 1 on the next cycle. If the buffer is empty, the active sample SHALL be 0 and underrun_o SHALL be 1 for exactly that one cycle.
REQ-019 Simultaneous boundary and write: the boundary SHALL use the buffer contents from before that edge. A write accepted in the same cycle (buffer was empty) SHALL fill the buffer for the next frame, and underrun_o still SHALL pulse.
REQ-020 The active sample SHALL be held unchanged for the whole frame; sample_i changes SHALL have no effect on the frame in progress.
REQ-021 Latency: a sample accepted during frame N SHALL appear starting slot 1 of frame N+1.

Reset
REQ-022 While reset_i is high: sclk_o=0, lrclk_o=0, sdata_o=0, underrun_o=0, ready_o=0, divider=0, slot=0, buffer empty, active sample=0.
REQ-023 Reset assertion mid-frame SHALL force all outputs to reset values immediately (asynchronously) and discard any buffered sample.
REQ-024 After reset release, the block SHALL start in slot 0 of a frame with active sample 0. underrun_o SHALL NOT pulse for this first frame; the first boundary check is at the first 63->0 slot edge.

Verification (clk_div_p=4; slot = 8 clk_i cycles, frame = 512)
REQ-025 Reset: hold reset_i 10 cycles -> all outputs 0 and ready_o=0; first cycle after release, ready_o=1; first sclk_o rise at cycle 4, first fall at cycle 8.
REQ-026 Single sample: push 24'hA5F00F in frame 0 -> frame 1 slots 1..24 = 1010_0101_1111_0000_0000_1111 with lrclk_o=0; slots 33..56 show the same pattern with lrclk_o=1; all other slots are 0.
REQ-027 Bit position: push 24'h800000 then 24'h000001 in consecutive frames -> the only 1 is at slots 1 and 33 in the first frame, and at slots 24 and 56 in the second frame.
REQ-028 Back-pressure: push A then hold valid_i with B -> ready_o stays 0 until the frame boundary; B is accepted the cycle after the boundary; A plays, then B plays in the following frame.
REQ-029 Underrun: no push for one full frame -> underrun_o is a single-cycle pulse at the boundary, and that frame's sdata_o is all 0.
REQ-030 Reset mid-frame: assert reset_i at slot 10 of a frame with buffer full -> outputs 0 immediately; after release, the first frame plays zeros and the discarded sample never appears.
